// File: rtl/addsub_share_arbiter.sv
// addsub_share_arbiter
//   Round-robin scheduler that shares one combinational two's-complement
//   adder/subtractor between two requesters. The granted request's operands
//   are muxed onto the shared adder. The adder's sum and overflow are
//   captured into a one-entry result buffer and returned with the id of the
//   requester that issued them.
//
//   Build option: define SATURATE_EN to clamp the captured sum on signed
//   overflow. The clamp is 0x7F..F when add_a is non-negative and 0x80..0
//   when add_a is negative. Without the macro the wrapped sum is returned.
//
// Ports
//   clk, rst_n                      clock (rising edge), async active-low reset
//   req0_valid/ready/a/b/op         requester 0 handshake and operation
//   req1_valid/ready/a/b/op         requester 1 handshake and operation
//   add_a/add_b/add_op              operands and op driven to the shared adder
//   add_sum/add_overflow            combinational result from the shared adder
//   rsp_valid/ready                 result buffer handshake
//   rsp_sum/rsp_overflow/rsp_id     buffered result, overflow flag, requester id
//
// state | meaning
// ------+--------------------------------------------
// EMPTY | result buffer free, any request may be accepted
// FULL  | result buffer holds a result for the consumer

module addsub_share_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_op,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_op,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_overflow,
  output logic             rsp_id
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_ptr;
  logic             w_ptr_nxt;
  logic [WIDTH-1:0] r_rsp_sum;
  logic             r_rsp_overflow;
  logic             r_rsp_id;

  logic             w_can_accept;
  logic             w_both;
  logic             w_gnt_id;
  logic             w_accept;
  logic [WIDTH-1:0] w_sum_cap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_ptr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_can_accept = (r_state == EMPTY) | rsp_ready;
    w_both       = req0_valid & req1_valid;
    // Under contention the pointer decides; otherwise the lone valid port wins.
    w_gnt_id     = w_both ? r_ptr : req1_valid;
    w_accept     = w_can_accept & (req0_valid | req1_valid);

    // Reset only gates the handshake outputs. The flops are already held by
    // the async reset, so their next-state logic does not need it.
    req0_ready   = rst_n & w_accept & ~w_gnt_id;
    req1_ready   = rst_n & w_accept &  w_gnt_id;

    if (w_accept && w_both) begin
      w_ptr_nxt = ~w_gnt_id;
    end

    case (r_state)
      EMPTY: begin
        if (w_accept) w_state_nxt = FULL;
      end
      FULL: begin
        if (w_accept)       w_state_nxt = FULL;
        else if (rsp_ready) w_state_nxt = EMPTY;
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  // Port 0 operands are shown whenever port 1 is not actually being granted.
  assign add_a  = (w_accept && w_gnt_id) ? req1_a  : req0_a;
  assign add_b  = (w_accept && w_gnt_id) ? req1_b  : req0_b;
  assign add_op = (w_accept && w_gnt_id) ? req1_op : req0_op;

`ifdef SATURATE_EN
  // Clamp toward the sign of operand a: 0111..1 for a >= 0, 1000..0 for a < 0.
  assign w_sum_cap = add_overflow ? {add_a[WIDTH-1], {(WIDTH-1){~add_a[WIDTH-1]}}}
                                  : add_sum;
`else
  assign w_sum_cap = add_sum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_sum      <= '0;
      r_rsp_overflow <= 1'b0;
      r_rsp_id       <= 1'b0;
    end else if (w_accept) begin
      r_rsp_sum      <= w_sum_cap;
      r_rsp_overflow <= add_overflow;
      r_rsp_id       <= w_gnt_id;
    end
  end

  assign rsp_valid    = (r_state == FULL);
  assign rsp_sum      = r_rsp_sum;
  assign rsp_overflow = r_rsp_overflow;
  assign rsp_id       = r_rsp_id;

endmodule

// File: tb/tb_addsub_share_arbiter.sv
// Bench for addsub_share_arbiter. Directed vectors with hand-computed
// expected values. The shared adder is modelled by the bench.
module tb_addsub_share_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req0_ready, req0_op;
  logic [7:0] req0_a, req0_b;
  logic       req1_valid, req1_ready, req1_op;
  logic [7:0] req1_a, req1_b;
  logic [7:0] add_a, add_b, add_sum;
  logic       add_op, add_overflow;
  logic       rsp_valid, rsp_ready, rsp_overflow, rsp_id;
  logic [7:0] rsp_sum;

  int checks = 0;
  int errors = 0;

`ifdef SATURATE_EN
  localparam logic [7:0] OVF_ADD_SUM = 8'h7F;
  localparam logic [7:0] OVF_SUB_SUM = 8'h80;
`else
  localparam logic [7:0] OVF_ADD_SUM = 8'h80;
  localparam logic [7:0] OVF_SUB_SUM = 8'h7F;
`endif

  addsub_share_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .add_a(add_a), .add_b(add_b), .add_op(add_op),
    .add_sum(add_sum), .add_overflow(add_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_overflow(rsp_overflow), .rsp_id(rsp_id)
  );

  // Shared adder/subtractor.
  always_comb begin
    add_sum = add_op ? (add_a - add_b) : (add_a + add_b);
    if (add_op) add_overflow = (add_a[7] != add_b[7]) && (add_sum[7] != add_a[7]);
    else        add_overflow = (add_a[7] == add_b[7]) && (add_sum[7] != add_a[7]);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h01; req0_op = 1'b0;
    req1_valid = 1'b0; req1_a = 8'h00; req1_b = 8'h00; req1_op = 1'b0;
    rsp_ready = 1'b1;
    #2;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (rsp_sum !== 8'h00) begin errors++; $display("FAIL reset_rsp_sum got %h want 00", rsp_sum); end
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_req0_ready got %b want 0", req0_ready); end
    repeat (2) @(posedge clk);
    #1;
    req0_valid = 1'b0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    req0_valid = 1'b1; req0_a = 8'h05; req0_b = 8'h03; req0_op = 1'b0;
    rsp_ready = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL single_ready got r0=%b r1=%b want r0=1 r1=0", req0_ready, req1_ready); end
    step();
    req0_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", rsp_valid); end
    checks++; if (rsp_sum !== 8'h08) begin errors++; $display("FAIL single_sum got %h want 08", rsp_sum); end
    checks++; if (rsp_overflow !== 1'b0) begin errors++; $display("FAIL single_ovf got %b want 0", rsp_overflow); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL single_id got %b want 0", rsp_id); end
    step();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b want 0", rsp_valid); end
  endtask

  task automatic test_contention();
    logic g;
    req0_valid = 1'b1; req0_a = 8'h10; req0_b = 8'h01; req0_op = 1'b0;
    req1_valid = 1'b1; req1_a = 8'h20; req1_b = 8'h05; req1_op = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      g = (i % 2 == 1);
      #1;
      checks++; if (req0_ready !== ~g || req1_ready !== g) begin errors++; $display("FAIL contend_grant[%0d] got r0=%b r1=%b want grant %b", i, req0_ready, req1_ready, g); end
      checks++; if (add_a !== (g ? 8'h20 : 8'h10)) begin errors++; $display("FAIL contend_add_a[%0d] got %h want %h", i, add_a, g ? 8'h20 : 8'h10); end
      step();
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== g) begin errors++; $display("FAIL contend_rsp[%0d] got v=%b id=%b want v=1 id=%b", i, rsp_valid, rsp_id, g); end
      checks++; if (rsp_sum !== (g ? 8'h1B : 8'h11)) begin errors++; $display("FAIL contend_sum[%0d] got %h want %h", i, rsp_sum, g ? 8'h1B : 8'h11); end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h01; req0_op = 1'b0;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL bp_fill_ready got %b want 1", req0_ready); end
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 8'h09; req1_b = 8'h02; req1_op = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_ready[%0d] got %b want 0", i, req1_ready); end
      checks++; if (rsp_valid !== 1'b1 || rsp_sum !== 8'h02 || rsp_id !== 1'b0) begin errors++; $display("FAIL bp_hold[%0d] got v=%b sum=%h id=%b want v=1 sum=02 id=0", i, rsp_valid, rsp_sum, rsp_id); end
      checks++; if (add_a !== 8'h01) begin errors++; $display("FAIL bp_idle_mux[%0d] got %h want 01", i, add_a); end
      step();
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", req1_ready); end
    step();
    req1_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_sum !== 8'h07 || rsp_id !== 1'b1) begin errors++; $display("FAIL bp_result got v=%b sum=%h id=%b want v=1 sum=07 id=1", rsp_valid, rsp_sum, rsp_id); end
    step();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b want 0", rsp_valid); end
  endtask

  task automatic test_overflow();
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 8'h7F; req0_b = 8'h01; req0_op = 1'b0;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL ovf_add_ready got %b want 1", req0_ready); end
    step();
    req0_valid = 1'b0;
    checks++; if (rsp_overflow !== 1'b1 || rsp_sum !== OVF_ADD_SUM) begin errors++; $display("FAIL ovf_add got ovf=%b sum=%h want ovf=1 sum=%h", rsp_overflow, rsp_sum, OVF_ADD_SUM); end
    req1_valid = 1'b1; req1_a = 8'h80; req1_b = 8'h01; req1_op = 1'b1;
    #1;
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL ovf_sub_ready got %b want 1", req1_ready); end
    step();
    req1_valid = 1'b0;
    checks++; if (rsp_overflow !== 1'b1 || rsp_sum !== OVF_SUB_SUM || rsp_id !== 1'b1) begin errors++; $display("FAIL ovf_sub got ovf=%b sum=%h id=%b want ovf=1 sum=%h id=1", rsp_overflow, rsp_sum, rsp_id, OVF_SUB_SUM); end
    step();
  endtask

  task automatic test_lone();
    rsp_ready = 1'b1;
    req1_valid = 1'b1; req1_b = 8'h02; req1_op = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req1_a = 8'h30 + 8'(i);
      #1;
      checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL lone_ready[%0d] got %b want 1", i, req1_ready); end
      step();
      checks++; if (rsp_valid !== 1'b1 || rsp_sum !== 8'h32 + 8'(i) || rsp_id !== 1'b1) begin errors++; $display("FAIL lone_rsp[%0d] got v=%b sum=%h id=%b want v=1 sum=%h id=1", i, rsp_valid, rsp_sum, rsp_id, 8'h32 + 8'(i)); end
    end
    req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h02; req0_op = 1'b0;
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL lone_then_contend got r0=%b r1=%b want r0=1 r1=0", req0_ready, req1_ready); end
    step();
    checks++; if (rsp_id !== 1'b0 || rsp_sum !== 8'h03) begin errors++; $display("FAIL lone_contend_rsp got id=%b sum=%h want id=0 sum=03", rsp_id, rsp_sum); end
    // Pointer now favours port 1; lone port-1 requests must leave it there.
    req0_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
    end
    req0_valid = 1'b1;
    #1;
    checks++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin errors++; $display("FAIL lone_ptr_hold got r0=%b r1=%b want r0=0 r1=1", req0_ready, req1_ready); end
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    // Fill the buffer under contention with the consumer stalled; pointer moves to 1.
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 8'h11; req0_b = 8'h11; req0_op = 1'b0;
    req1_valid = 1'b1; req1_a = 8'h22; req1_b = 8'h01; req1_op = 1'b0;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL rmid_fill_ready got %b want 1", req0_ready); end
    step();
    checks++; if (rsp_valid !== 1'b1 || rsp_sum !== 8'h22) begin errors++; $display("FAIL rmid_full got v=%b sum=%h want v=1 sum=22", rsp_valid, rsp_sum); end
    rst_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0 || rsp_sum !== 8'h00 || rsp_overflow !== 1'b0 || rsp_id !== 1'b0) begin errors++; $display("FAIL rmid_clear got v=%b sum=%h ovf=%b id=%b want all 0", rsp_valid, rsp_sum, rsp_overflow, rsp_id); end
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL rmid_ready got r0=%b r1=%b want 0 0", req0_ready, req1_ready); end
    step();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL rmid_ptr got r0=%b r1=%b want r0=1 r1=0", req0_ready, req1_ready); end
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_overflow();
    test_lone();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/addsub_share_arbiter.md
Name: addsub_share_arbiter

Overview:
- Round-robin scheduler that shares one combinational 8-bit two's-complement adder/subtractor between two requesters (port 0, port 1).
- Drives the adder's a/b/op inputs, captures its sum/overflow into a one-entry result buffer, and returns the result with a tag naming the requester.
- Sits between client FSMs and the single shared adder instance.

Parameters:
- WIDTH, 8, operand/result width; must match the shared adder (8 in this design).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_a  input  WIDTH  requester 0 operand a
- req0_b  input  WIDTH  requester 0 operand b
- req0_op  input  1  requester 0 op: 0 = add, 1 = subtract (a-b)
- req1_valid  input  1  requester 1 has an operation
- req1_ready  output  1  requester 1 operation accepted
- req1_a  input  WIDTH  requester 1 operand a
- req1_b  input  WIDTH  requester 1 operand b
- req1_op  input  1  requester 1 op
- add_a  output  WIDTH  to shared adder a
- add_b  output  WIDTH  to shared adder b
- add_op  output  1  to shared adder op
- add_sum  input  WIDTH  from shared adder sum (combinational)
- add_overflow  input  1  from shared adder signed overflow
- rsp_valid  output  1  result buffer holds a result
- rsp_ready  input  1  consumer takes result
- rsp_sum  output  WIDTH  registered result
- rsp_overflow  output  1  registered signed overflow
- rsp_id  output  1  requester that issued the result

Behaviour:
- Reset (rst_n low, asynchronous): rsp_valid=0, rsp_sum=0, rsp_overflow=0, rsp_id=0, round-robin pointer=0 (port 0 favoured), state=EMPTY. req*_ready=0 while in reset.
- States: EMPTY (buffer free), FULL (buffer holds result).
- can_accept = (state==EMPTY) | (rsp_valid & rsp_ready).
- Grant (combinational): if can_accept and only one valid, grant that port. If both valid, grant the port named by the pointer. reqN_ready = can_accept & grant==N. At most one ready high per cycle.
- add_a/add_b/add_op are muxed combinationally from the granted port. With no grant they show port 0 inputs; the adder output is ignored.
- On accept (valid & ready): at the next edge, load rsp_sum=add_sum, rsp_overflow=add_overflow, rsp_id=granted port; state=FULL. Latency is 1 cycle from accept to rsp_valid.
- Pointer updates only when both ports were valid and one was granted; it moves to the other port. A lone request does not move the pointer.
- FULL & rsp_ready & no accept -> EMPTY. FULL & rsp_ready & accept -> stays FULL with the new result (back-to-back, one result per cycle).
- FULL & !rsp_ready: outputs hold stable; no request accepted; requester inputs may change freely.
- Requesters must hold valid/operands until ready. Dropping valid before ready is allowed; nothing is latched.
- Arithmetic is wrap-around modulo 2^WIDTH; overflow is passed through unmodified from the adder.
- Reset asserted mid-operation discards any buffered result immediately.

Optional Feature:
- Macro SATURATE_EN.
- Defined: when add_overflow=1 at capture, rsp_sum is clamped. add with a[7]=0 gives 8'h7F; add with a[7]=1 gives 8'h80. For subtract, same rule using a[7]. rsp_overflow is still 1.
- Undefined: rsp_sum = add_sum unmodified (wrapped).

Test Plan:
- Reset: rst_n low mid-FULL -> rsp_valid=0, rsp_sum=0 immediately; after release, port 0 favoured on first contention.
- Single request: req0 a=8'h05 b=8'h03 op=0, rsp_ready=1 -> req0_ready same cycle; next cycle rsp_valid=1, sum=8'h08, ovf=0, id=0.
- Contention: both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1, one result per cycle, rsp_id alternating.
- Backpressure: result in FULL, rsp_ready=0 for 3 cycles with req1 valid -> req1_ready=0, rsp outputs stable. Raise rsp_ready -> req1 accepted that same cycle.
- Overflow: a=8'h7F b=8'h01 op=0 -> rsp_overflow=1, sum=8'h80 (8'h7F with SATURATE_EN). a=8'h80 b=8'h01 op=1 -> ovf=1, sum=8'h7F (8'h80 with SATURATE_EN).
- Lone requester: req1 only, 4 times -> all granted back-to-back; pointer unchanged, so the next contention grants port 0.
